// File: rtl/dmem_arbiter.sv
// Data memory arbiter: the pipeline MEM stage owns data_mem by default; a debug/loader
// port is served when the pipeline is idle or after it has starved STARVE_LIMIT cycles.
// Optional stall statistics port enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_valid,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_MemWrite,
  output logic              dm_MemRead,
  input  logic [DATA_W-1:0] dm_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       stall_cycles,
`endif
  output logic              fsm_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_DBG = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic                cap_we;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic                dbg_win;

  // Debug handshake: the requester holds dbg_req and its operands until the cycle in
  // which dbg_gnt is high (operands captured at that edge); dbg_valid pulses two
  // cycles later, carrying dbg_rdata for reads. There is no back-pressure on dbg_valid.
  assign dbg_win   = dbg_req & (~mem_req | (wait_cnt == LIMIT));
  assign dbg_gnt   = reset_n & (state == ST_IDLE) & dbg_win;
  assign fsm_state = state;

  always_comb begin
    dm_addr     = mem_addr;
    dm_wdata    = mem_wdata;
    dm_MemWrite = reset_n & mem_req & mem_we;
    dm_MemRead  = reset_n & mem_req & ~mem_we;
    mem_rdata   = dm_rdata;
    mem_stall   = 1'b0;
    if (state == ST_DBG) begin
      dm_addr     = cap_addr;
      dm_wdata    = cap_wdata;
      dm_MemWrite = reset_n & cap_we;
      dm_MemRead  = reset_n & ~cap_we;
      mem_rdata   = '0;
      mem_stall   = reset_n & mem_req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      dbg_rdata <= '0;
      dbg_valid <= 1'b0;
    end else begin
      dbg_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dbg_win) begin
            cap_we    <= dbg_we;
            cap_addr  <= dbg_addr;
            cap_wdata <= dbg_wdata;
            wait_cnt  <= '0;
            state     <= ST_DBG;
          end else if (dbg_req) begin
            wait_cnt <= (wait_cnt == LIMIT) ? LIMIT : wait_cnt + 1'b1;
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_DBG: begin
          // wait_cnt is already zero here, so a waiting pipeline gets the next cycle.
          if (!cap_we) dbg_rdata <= dm_rdata;
          dbg_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (mem_stall && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven pipeline passthrough vectors plus
// hand-written debug, starvation and reset-in-flight sequences with a dbg_rdata scoreboard.
module tb_dmem_arbiter;

  logic       clk;
  logic       reset_n;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_stall;
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       dbg_gnt;
  logic [7:0] dbg_rdata;
  logic       dbg_valid;
  logic [7:0] dm_addr, dm_wdata, dm_rdata;
  logic       dm_MemWrite, dm_MemRead;
  logic       fsm_state;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cycles;
`endif

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_MemWrite(dm_MemWrite),
    .dm_MemRead(dm_MemRead), .dm_rdata(dm_rdata),
`ifdef DMEM_ARB_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory model with combinational read
  logic [7:0] mem [0:255];
  always @(posedge clk) if (dm_MemWrite) mem[dm_addr] <= dm_wdata;
  assign dm_rdata = mem[dm_addr];

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd;

  function void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // scoreboard: every dbg_valid pops one expected dbg_rdata
  always @(negedge clk) begin
    if (reset_n && dbg_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL dbg_valid_unexpected: got dbg_valid=1 expected 0");
      end else begin
        check("dbg_rdata", dbg_rdata, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_wr;
    logic       exp_rd;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
    int gnt_at;
    gnt_at = 0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    for (int c = 1; c <= 8 && gnt_at == 0; c++) begin
      @(negedge clk);
      if (dbg_gnt) gnt_at = c;
      step();
    end
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
    check("dbg_gnt_cycle", gnt_at, 1);
    if (gnt_at != 0) begin
      if (we) exp_q.push_back(last_rd);
      else begin
        exp_q.push_back(exp_rd);
        last_rd = exp_rd;
      end
      @(negedge clk);
      check("dbg_access_we", dm_MemWrite, we);
      check("dbg_access_rd", dm_MemRead, !we);
      check("dbg_access_addr", dm_addr, a);
      if (we) check("dbg_access_wdata", dm_wdata, d);
      check("dbg_valid_early", dbg_valid, 0);
      check("fsm_in_dbg", fsm_state, 1);
      step();
      @(negedge clk);
      check("dbg_valid_n2", dbg_valid, 1);
      step();
    end
  endtask

  task automatic starve_run(input logic drop_first);
    int gnt_at;
    int stalls;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h20;
    dbg_we = 1'b0; dbg_addr = 8'h40;
    if (drop_first) begin
      dbg_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("drop_no_gnt", dbg_gnt, 0);
        step();
      end
      dbg_req = 1'b0;
      step();
    end
    gnt_at = 0;
    stalls = 0;
    dbg_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      if (dbg_gnt && gnt_at == 0) begin
        gnt_at = c;
        exp_q.push_back(8'h5A);
        last_rd = 8'h5A;
      end
      if (gnt_at != 0 && c == gnt_at + 1) begin
        check("starve_stall_rdata", mem_rdata, 8'h00);
        check("starve_dbg_addr", dm_addr, 8'h40);
        check("starve_dbg_rd", dm_MemRead, 1);
      end
      if (gnt_at != 0 && c == gnt_at + 2) begin
        check("starve_pipe_back", mem_rdata, 8'h3C);
        check("starve_pipe_addr", dm_addr, 8'h20);
      end
      step();
      if (gnt_at != 0) dbg_req = 1'b0;
    end
    dbg_req = 1'b0;
    check("starve_gnt_cycle", gnt_at, 5);
    check("starve_stall_count", stalls, 1);
    mem_req = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C; mem[8'h21] = 8'hC3; mem[8'h30] = 8'h11; mem[8'h40] = 8'h5A;
    last_rd = 8'h00;
    vecs[0] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 8'h3C};
    vecs[1] = '{1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 1'b1, 8'hC3};
    vecs[2] = '{1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h3C};
    vecs[3] = '{1'b1, 1'b1, 8'h50, 8'h99, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b1, 8'h99};

    // T1: reset held with both requesters active
    reset_n = 1'b0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h30; mem_wdata = 8'hEE;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 8'hEE;
    @(negedge clk);
    check("rst_gnt", dbg_gnt, 0);
    check("rst_valid", dbg_valid, 0);
    check("rst_memwrite", dm_MemWrite, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    step();
    mem_req = 1'b0;
    @(negedge clk);
    check("rst_gnt_idle_pipe", dbg_gnt, 0);
    check("rst_memread", dm_MemRead, 0);
    step();
    dbg_req = 1'b0; dbg_we = 1'b0; mem_we = 1'b0; mem_wdata = 8'h00;
    reset_n = 1'b1;
    step();
    check("rst_mem30_kept", mem[8'h30], 8'h11);

    // T3 and passthrough vectors
    foreach (vecs[i]) begin
      mem_req = vecs[i].req; mem_we = vecs[i].we;
      mem_addr = vecs[i].addr; mem_wdata = vecs[i].wdata;
      @(negedge clk);
      check("pt_memwrite", dm_MemWrite, vecs[i].exp_wr);
      check("pt_memread", dm_MemRead, vecs[i].exp_rd);
      check("pt_rdata", mem_rdata, vecs[i].exp_rdata);
      check("pt_addr", dm_addr, vecs[i].addr);
      check("pt_stall", mem_stall, 0);
      step();
    end
    mem_req = 1'b0; mem_we = 1'b0;
    step();

    // T2: debug write then read, pipeline idle
    dbg_op(1'b1, 8'h10, 8'hA5, 8'h00);
    dbg_op(1'b0, 8'h10, 8'h00, 8'hA5);
    check("dbg_write_landed", mem[8'h10], 8'hA5);

    // T5: reset during the debug cycle of a write
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 8'h77;
    @(negedge clk);
    check("t5_gnt", dbg_gnt, 1);
    step();
    dbg_req = 1'b0; dbg_we = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t5_state_idle", fsm_state, 0);
    check("t5_no_write", dm_MemWrite, 0);
    step();
    reset_n = 1'b1;
    last_rd = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_no_valid", dbg_valid, 0);
      step();
    end
    check("t5_mem_unchanged", mem[8'h30], 8'h11);
    check("t5_dbg_rdata_cleared", dbg_rdata, 0);
`ifdef DMEM_ARB_STATS_EN
    check("t5_stats_cleared", stall_cycles, 0);
`endif

    // T4 / T6: starvation preemption, third run preceded by an abandoned request
    starve_run(1'b0);
    starve_run(1'b0);
    starve_run(1'b1);
`ifdef DMEM_ARB_STATS_EN
    check("stall_cycles", stall_cycles, 3);
`endif

    repeat (3) step();
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
